// File: rtl/mem_pkg.sv
// Shared definitions for the load/store MEM stage: op codes, FSM encoding
// and size/sign decode helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWU  = 4'd6,
    OP_LD   = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LD);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SD);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH:        return 2'd1;
      OP_LW, OP_LWU, OP_SW:        return 2'd2;
      OP_LD, OP_SD:                return 2'd3;
      default:                     return 2'd0;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte-enables and replication, load
// extraction with sign/zero extension, misalign/illegal detection.
module mem_align #(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic [3:0]        i_chk_op,
  input  logic [OFF_W-1:0]  i_chk_off,
  input  logic [3:0]        i_op,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [BE_W-1:0]   o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_misalign,
  output logic              o_illegal
);
  import mem_pkg::*;

  logic [1:0]        w_sz;
  logic [1:0]        w_chk_sz;
  logic [7:0]        w_mask8;
  logic [2:0]        w_chk_off3;
  logic [2:0]        w_chk_amask;
  logic [DATA_W-1:0] w_lane;
  logic              w_signed;

  always_comb begin
    w_sz     = op_size(i_op);
    w_signed = op_is_signed(i_op);
    case (w_sz)
      2'd0:    w_mask8 = 8'h01;
      2'd1:    w_mask8 = 8'h03;
      2'd2:    w_mask8 = 8'h0f;
      default: w_mask8 = 8'hff;
    endcase

    o_be = '0;
    if (op_is_load(i_op) || op_is_store(i_op))
      o_be = w_mask8[BE_W-1:0] << i_off;

    case (w_sz)
      2'd0:    o_wdata = {BE_W{i_wdata[7:0]}};
      2'd1:    o_wdata = {(BE_W/2){i_wdata[15:0]}};
      2'd2:    o_wdata = {(BE_W/4){i_wdata[31:0]}};
      default: o_wdata = i_wdata;
    endcase

    w_lane = i_rdata >> {i_off, 3'b000};
    case (w_sz)
      2'd0: begin
        if (w_signed) o_rdata = DATA_W'($signed(w_lane[7:0]));
        else          o_rdata = DATA_W'(w_lane[7:0]);
      end
      2'd1: begin
        if (w_signed) o_rdata = DATA_W'($signed(w_lane[15:0]));
        else          o_rdata = DATA_W'(w_lane[15:0]);
      end
      2'd2: begin
        if (w_signed) o_rdata = DATA_W'($signed(w_lane[31:0]));
        else          o_rdata = DATA_W'(w_lane[31:0]);
      end
      default: o_rdata = w_lane;
    endcase

    // Detection runs on the incoming op so the accept edge can route it.
    w_chk_sz    = op_size(i_chk_op);
    w_chk_off3  = 3'(i_chk_off);
    w_chk_amask = 3'((4'd1 << w_chk_sz) - 4'd1);
    o_illegal   = (i_chk_op > OP_SD) ||
                  ((DATA_W == 32) && ((i_chk_op == OP_LD) || (i_chk_op == OP_SD)));
    o_misalign  = (op_is_load(i_chk_op) || op_is_store(i_chk_op)) &&
                  ((w_chk_off3 & w_chk_amask) != 3'd0);
  end

endmodule

// File: rtl/mem_stage_ls.sv
// Load/store MEM stage between EX and WB: one op in flight, SRAM req/gnt/rvalid
// port, valid/ready on both pipeline sides and a forwarding bus to ID.
//   state | meaning
//   IDLE  | empty, ready for an op
//   REQ   | mem_req held until mem_gnt
//   WAIT  | load granted, waiting for mem_rvalid
//   DONE  | result presented to WB until out_ready
module mem_stage_ls #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFF_W  = $clog2(BE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [DATA_W-1:0] in_ex_result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic              out_rf_we,
  output logic [4:0]        out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic              out_exc,
  output logic              fwd_pending,
  output logic              fwd_valid,
  output logic [4:0]        fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata
);
  import mem_pkg::*;

  state_e            r_state;
  logic [31:0]       r_pc;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rf_we;
  logic [4:0]        r_rf_waddr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_exc;

  logic              w_accept;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_in_exc;
  logic [DATA_W-1:0] w_load_data;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .i_chk_op   (in_op),
    .i_chk_off  (in_addr[OFF_W-1:0]),
    .i_op       (r_op),
    .i_off      (r_addr[OFF_W-1:0]),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_rdata),
    .o_be       (mem_be),
    .o_wdata    (mem_wdata),
    .o_rdata    (w_load_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_in_exc = w_misalign || w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_op       <= OP_NONE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_wb_data  <= '0;
      r_exc      <= 1'b0;
    end else if (w_accept) begin
      r_pc       <= in_pc;
      r_op       <= in_op;
      r_addr     <= in_addr;
      r_wdata    <= in_wdata;
      r_rf_we    <= in_rf_we;
      r_rf_waddr <= in_rf_waddr;
      r_wb_data  <= in_ex_result;
      r_exc      <= w_in_exc;
      r_state    <= ((in_op == OP_NONE) || w_in_exc) ? ST_DONE : ST_REQ;
    end else begin
      case (r_state)
        ST_REQ:  if (mem_gnt) r_state <= op_is_store(r_op) ? ST_DONE : ST_WAIT;
        ST_WAIT: if (mem_rvalid) begin
                   r_wb_data <= w_load_data;
                   r_state   <= ST_DONE;
                 end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: ;
      endcase
    end
  end

  assign mem_req      = (r_state == ST_REQ);
  assign mem_we       = mem_req && op_is_store(r_op);
  assign mem_addr     = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign out_valid    = (r_state == ST_DONE);
  assign out_pc       = r_pc;
  assign out_rf_we    = out_valid && r_rf_we && !r_exc;
  assign out_rf_waddr = r_rf_waddr;
  assign out_rf_wdata = r_wb_data;
  assign out_exc      = out_valid && r_exc;

  assign fwd_pending  = r_rf_we && op_is_load(r_op) &&
                        ((r_state == ST_REQ) || (r_state == ST_WAIT));
  assign fwd_valid    = out_valid && out_rf_we;
  assign fwd_waddr    = r_rf_waddr;
  assign fwd_wdata    = r_wb_data;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls (DATA_W=32): loads, stores, exceptions,
// WB backpressure and reset in the middle of a load.
module tb_mem_stage_ls;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [31:0] in_ex_result;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_rf_wdata;
  logic        out_exc;
  logic        fwd_pending;
  logic        fwd_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  mem_stage_ls #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_op        (in_op),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rf_we     (in_rf_we),
    .in_rf_waddr  (in_rf_waddr),
    .in_ex_result (in_ex_result),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rf_we    (out_rf_we),
    .out_rf_waddr (out_rf_waddr),
    .out_rf_wdata (out_rf_wdata),
    .out_exc      (out_exc),
    .fwd_pending  (fwd_pending),
    .fwd_valid    (fwd_valid),
    .fwd_waddr    (fwd_waddr),
    .fwd_wdata    (fwd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic [31:0] ex);
    in_valid     = 1'b1;
    in_op        = op;
    in_addr      = addr;
    in_wdata     = wdata;
    in_pc        = pc;
    in_ex_result = ex;
    in_rf_we     = 1'b1;
    in_rf_waddr  = 5'd7;
  endtask

  // gnt in the first REQ cycle, rvalid in the cycle after
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    drive(op, addr, 32'h0, 32'h2000, 32'h0);
    mem_gnt = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ".req"}, mem_req, 1);
    chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".pend_req"}, fwd_pending, 1);
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    chk({tag, ".pend_wait"}, fwd_pending, 1);
    chk({tag, ".early_valid"}, out_valid, 0);
    step();
    mem_rvalid = 1'b0;
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".wdata"}, out_rf_wdata, exp);
    chk({tag, ".fwd_valid"}, fwd_valid, 1);
    chk({tag, ".fwd_waddr"}, fwd_waddr, 7);
    step();
    chk({tag, ".idle"}, out_valid, 0);
  endtask

  task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int gnt_delay);
    mem_gnt = 1'b0;
    drive(op, addr, wdata, 32'h3000, 32'h0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      chk({tag, ".req"}, mem_req, 1);
      chk({tag, ".we"}, mem_we, 1);
      chk({tag, ".be"}, mem_be, exp_be);
      chk({tag, ".wd"}, mem_wdata, exp_wd);
      chk({tag, ".no_valid"}, out_valid, 0);
      if (i == gnt_delay) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".req_drop"}, mem_req, 0);
    step();
  endtask

  task automatic do_exc(input string tag, input logic [3:0] op, input logic [31:0] addr);
    drive(op, addr, 32'h0, 32'h4000, 32'h55);
    step();
    in_valid = 1'b0;
    chk({tag, ".no_req"}, mem_req, 0);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".exc"}, out_exc, 1);
    chk({tag, ".rf_we"}, out_rf_we, 0);
    chk({tag, ".fwd_valid"}, fwd_valid, 0);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_op = '0; in_addr = '0; in_wdata = '0;
    in_rf_we = 1'b0; in_rf_waddr = '0; in_ex_result = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_be", mem_be, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.fwd_pending", fwd_pending, 0);
    chk("rst.out_rf_we", out_rf_we, 0);
    chk("rst.out_exc", out_exc, 0);
    step();

    do_load("lw",   4'd5, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb",   4'd1, 32'h103, 32'h80112233, 32'hFFFFFF80);
    do_load("lbu",  4'd2, 32'h103, 32'h80112233, 32'h00000080);
    do_load("lh",   4'd3, 32'h102, 32'h80112233, 32'hFFFF8011);
    do_load("lhu",  4'd4, 32'h102, 32'h80112233, 32'h00008011);
    do_load("lb1",  4'd1, 32'h101, 32'h80112233, 32'h00000022);

    do_store("sh", 4'd9,  32'h102, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 3);
    do_store("sb", 4'd8,  32'h101, 32'h0000005A, 4'b0010, 32'h5A5A5A5A, 0);
    do_store("sw", 4'd10, 32'h104, 32'h12345678, 4'b1111, 32'h12345678, 1);

    do_exc("lw_mis", 4'd5,  32'h101);
    do_exc("lh_mis", 4'd3,  32'h103);
    do_exc("ld_ill", 4'd7,  32'h100);
    do_exc("op_ill", 4'd13, 32'h100);

    out_ready = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 32'h40, 32'h12345678);
    step();
    chk("bp.valid", out_valid, 1);
    chk("bp.rf_we", out_rf_we, 1);
    drive(4'd0, 32'h0, 32'h0, 32'h44, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      chk("bp.in_ready", in_ready, 0);
      chk("bp.hold_data", out_rf_wdata, 32'h12345678);
      chk("bp.hold_pc", out_pc, 32'h40);
      chk("bp.hold_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_rise", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp.next_valid", out_valid, 1);
    chk("bp.next_data", out_rf_wdata, 32'hCAFEF00D);
    chk("bp.next_pc", out_pc, 32'h44);
    step();
    chk("bp.idle", out_valid, 0);

    drive(4'd5, 32'h200, 32'h0, 32'h50, 32'h0);
    mem_gnt = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    mem_gnt = 1'b0;
    chk("rw.pend_wait", fwd_pending, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw.in_ready", in_ready, 1);
    chk("rw.out_valid", out_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAADF00D;
    step();
    mem_rvalid = 1'b0;
    chk("rw.stray_valid", out_valid, 0);
    chk("rw.stray_ready", in_ready, 1);
    chk("rw.stray_req", mem_req, 0);
    chk("rw.stray_pend", fwd_pending, 0);
    step();
    chk("rw.later_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
